// File: rtl/uart_pkg.sv
// uart_pkg: parity modes, serialiser state encoding and baud divider shared by the UART blocks
package uart_pkg;
   localparam int PARITY_NONE = 0;
   localparam int PARITY_ODD  = 1;
   localparam int PARITY_EVEN = 2;
   typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} uart_state_e;
   function automatic int baud_cnt_max(input int clk_freq, input int bps);
      return clk_freq / bps;
   endfunction
endpackage

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: single-clock DEPTH x WIDTH word buffer; clk/rst, i_push/i_pop, i_data in; o_data (head), o_full, o_empty, o_count out
module uart_tx_fifo #(
   parameter int DEPTH = 4,
   parameter int WIDTH = 8
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   i_push,
   input  logic                   i_pop,
   input  logic [WIDTH-1:0]       i_data,
   output logic [WIDTH-1:0]       o_data,
   output logic                   o_full,
   output logic                   o_empty,
   output logic [$clog2(DEPTH):0] o_count
);
   localparam int AW = $clog2(DEPTH);
   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [AW-1:0]    r_wr, r_rd;
   logic [AW:0]      r_count;
   logic             w_push, w_pop;
   // a push while full is dropped even when a pop happens in the same cycle
   assign w_push  = i_push && !o_full;
   assign w_pop   = i_pop && !o_empty;
   assign o_full  = r_count == (AW+1)'(DEPTH);
   assign o_empty = r_count == '0;
   assign o_data  = r_mem[r_rd];
   assign o_count = r_count;
   always_ff @(posedge clk) begin
      if (rst) begin
         r_wr    <= '0;
         r_rd    <= '0;
         r_count <= '0;
      end else begin
         r_wr    <= r_wr + AW'(w_push);
         r_rd    <= r_rd + AW'(w_pop);
         r_count <= r_count + (AW+1)'(w_push) - (AW+1)'(w_pop);
      end
   end
   always_ff @(posedge clk) begin
      if (w_push) r_mem[r_wr] <= i_data;
   end
endmodule

// File: rtl/uart_tx_param.sv
// uart_tx_param: buffered UART transmitter; pi_data/pi_valid/pi_ready word input, tx serial out (idle high), busy and fifo_count status
module uart_tx_param
   import uart_pkg::*;
#(
   parameter int CLK_FREQ    = 50000000,
   parameter int UART_BPS    = 9600,
   parameter int DATA_BITS   = 8,
   parameter int PARITY_MODE = 0,
   parameter int STOP_BITS   = 1,
   parameter int FIFO_DEPTH  = 4
) (
   input  logic                        system_clk,
   input  logic                        system_rst,
   input  logic [DATA_BITS-1:0]        pi_data,
   input  logic                        pi_valid,
   output logic                        pi_ready,
   output logic                        tx,
   output logic                        busy,
   output logic [$clog2(FIFO_DEPTH):0] fifo_count
);
   localparam int BAUD = baud_cnt_max(CLK_FREQ, UART_BPS);
   localparam int BW   = (BAUD < 2) ? 1 : $clog2(BAUD);
   localparam int IW   = $clog2(DATA_BITS);
   if (BAUD < 2 || DATA_BITS < 5 || DATA_BITS > 9 || STOP_BITS < 1 || STOP_BITS > 2 ||
       PARITY_MODE < 0 || PARITY_MODE > 2 || FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_param
      $error("uart_tx_param: illegal parameter combination");
   end
   uart_state_e          r_state, w_state;
   logic [BW-1:0]        r_baud_cnt, w_baud_cnt;
   logic [IW-1:0]        r_bit_idx, w_bit_idx;
   logic                 r_stop_idx, w_stop_idx;
   logic [DATA_BITS-1:0] r_shift, w_shift, w_head;
   logic                 r_par, w_par, r_tx, w_tx;
   logic                 w_wrap, w_load, w_full, w_empty;
   uart_tx_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(DATA_BITS)) u_fifo (
      .clk     (system_clk),
      .rst     (system_rst),
      .i_push  (pi_valid),
      .i_pop   (w_load),
      .i_data  (pi_data),
      .o_data  (w_head),
      .o_full  (w_full),
      .o_empty (w_empty),
      .o_count (fifo_count)
   );
   assign pi_ready = !w_full;
   assign tx       = r_tx;
   assign busy     = (r_state != S_IDLE) || !w_empty;
   assign w_wrap   = r_baud_cnt == BW'(BAUD - 1);
   // a new word is taken from idle, or on the last cycle of the final stop bit so frames abut
   assign w_load   = !w_empty && (r_state == S_IDLE ||
                     (r_state == S_STOP && w_wrap && r_stop_idx == 1'(STOP_BITS - 1)));
   always_comb begin
      w_state    = r_state;
      w_bit_idx  = r_bit_idx;
      w_stop_idx = r_stop_idx;
      w_shift    = r_shift;
      w_par      = r_par;
      w_tx       = r_tx;
      w_baud_cnt = (r_state == S_IDLE || w_wrap) ? '0 : r_baud_cnt + 1'b1;
      case (r_state)
         S_START: if (w_wrap) begin
            w_state   = S_DATA;
            w_bit_idx = '0;
            w_tx      = r_shift[0];
            w_shift   = r_shift >> 1;
         end
         S_DATA: if (w_wrap) begin
            if (r_bit_idx == IW'(DATA_BITS - 1)) begin
               w_state    = (PARITY_MODE != PARITY_NONE) ? S_PARITY : S_STOP;
               w_tx       = (PARITY_MODE != PARITY_NONE) ? r_par : 1'b1;
               w_stop_idx = 1'b0;
            end else begin
               w_bit_idx = r_bit_idx + 1'b1;
               w_tx      = r_shift[0];
               w_shift   = r_shift >> 1;
            end
         end
         S_PARITY: if (w_wrap) begin
            w_state    = S_STOP;
            w_tx       = 1'b1;
            w_stop_idx = 1'b0;
         end
         S_STOP: if (w_wrap) begin
            w_state    = (r_stop_idx == 1'(STOP_BITS - 1)) ? S_IDLE : S_STOP;
            w_stop_idx = r_stop_idx + 1'b1;
         end
         default: ;
      endcase
      // parity is captured from the whole word at load since the shift register is consumed bit by bit
      if (w_load) begin
         w_state = S_START;
         w_tx    = 1'b0;
         w_shift = w_head;
         w_par   = (PARITY_MODE == PARITY_EVEN) ? ^w_head : ~^w_head;
      end
   end
   always_ff @(posedge system_clk) begin
      if (system_rst) begin
         r_state    <= S_IDLE;
         r_baud_cnt <= '0;
         r_bit_idx  <= '0;
         r_stop_idx <= 1'b0;
         r_shift    <= '0;
         r_par      <= 1'b0;
         r_tx       <= 1'b1;
      end else begin
         r_state    <= w_state;
         r_baud_cnt <= w_baud_cnt;
         r_bit_idx  <= w_bit_idx;
         r_stop_idx <= w_stop_idx;
         r_shift    <= w_shift;
         r_par      <= w_par;
         r_tx       <= w_tx;
      end
   end
endmodule

// File: doc/uart_tx_param.md
Name: uart_tx_param

Overview:
Parametrised UART transmitter, the successor to the fixed 8N1 transmitter. It accepts words over a valid/ready handshake into a small internal FIFO and serialises them LSB-first on tx. Data width, parity mode, stop-bit count, baud rate and buffer depth are all configurable. It sits between any byte/word producer (rx loopback, command generator) and the board UART pin; back-to-back frames are sent with no idle gap.

Parameters:
CLK_FREQ, 50000000, system clock frequency in Hz
UART_BPS, 9600, baud rate; BAUD_CNT_MAX = CLK_FREQ/UART_BPS cycles per bit (integer divide, must be >= 2)
DATA_BITS, 8, payload bits per frame, legal 5..9
PARITY_MODE, 0, 0 = none, 1 = odd, 2 = even
STOP_BITS, 1, legal 1 or 2
FIFO_DEPTH, 4, entries in the input buffer, power of two, >= 2

Ports:
system_clk  in  1  clock
system_rst  in  1  reset; one clock; reset is synchronous and active-high
pi_data  in  DATA_BITS  word to send
pi_valid  in  1  pi_data valid this cycle
pi_ready  out  1  FIFO can accept; a push occurs when pi_valid && pi_ready
tx  out  1  serial line, idle high
busy  out  1  high while a frame is on the line or the FIFO is non-empty
fifo_count  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy

Behaviour:
- Reset (system_rst=1 at a clock edge): tx=1, busy=0, pi_ready=1, fifo_count=0. The FIFO is flushed and the FSM goes to IDLE. Reset mid-frame aborts the frame; tx returns high on that same edge.
- pi_ready = (fifo_count != FIFO_DEPTH), combinational from registered count. A push while full is dropped, and pi_ready=0 prevents it. There is no push-through-when-full, even if a pop occurs in the same cycle.
- Simultaneous push and pop: the count is unchanged and both take effect.
- FSM states: IDLE, START, DATA, PARITY, STOP.
  - IDLE: tx=1, baud_cnt held at 0. If the FIFO is non-empty, pop the head into the shift register, tx<=0, and go to START.
  - START: lasts BAUD_CNT_MAX cycles, then tx<=shift[0], go to DATA with bit_idx=0.
  - DATA: each bit lasts BAUD_CNT_MAX cycles, sent LSB first. After bit DATA_BITS-1, go to PARITY if PARITY_MODE != 0, otherwise go to STOP.
  - PARITY: bit = ^word for even, ~^word for odd. Lasts BAUD_CNT_MAX cycles.
  - STOP: tx=1 for STOP_BITS*BAUD_CNT_MAX cycles. On the final cycle: if the FIFO is non-empty, pop, tx<=0, go to START (zero gap); otherwise go to IDLE.
- Bit timing: baud_cnt counts 0..BAUD_CNT_MAX-1 and wraps. The state/bit advances on the wrap, so every bit is exactly BAUD_CNT_MAX cycles. tx is a registered output and is glitch-free.
- Latency: push accepted at edge k makes the FIFO non-empty after k. The IDLE pop occurs at edge k+1, and tx falls at edge k+1.
- Frame length: (1 + DATA_BITS + (PARITY_MODE != 0) + STOP_BITS) * BAUD_CNT_MAX cycles.
- busy = (state != IDLE) || (fifo_count != 0).
- Width rules: baud_cnt width is $clog2(BAUD_CNT_MAX). bit_idx width is $clog2(DATA_BITS). The stop counter counts bits, not cycles.
- Illegal parameter values (BAUD_CNT_MAX < 2, DATA_BITS outside 5..9, STOP_BITS outside 1..2, PARITY_MODE > 2, FIFO_DEPTH not a power of two) cause an elaboration-time error.

Decomposition:
- Package uart_pkg holds:
  - PARITY_NONE/ODD/EVEN constants
  - FSM state encoding
  - a function baud_cnt_max(clk_freq, bps)
  These are shared with the future parametrised receiver.
- Sub-module uart_tx_fifo: synchronous single-clock FIFO (FIFO_DEPTH x DATA_BITS), with push/pop, full/empty and a count output. The serialiser FSM stays in uart_tx_param.

Test Plan:
1. CLK_FREQ=1000, UART_BPS=100 (10 cycles/bit), 8N1; push 0xA5 -> tx falls 1 edge after the push and carries 0,1,0,1,0,0,1,0,1,1, each bit 10 cycles; busy drops after 100 cycles.
2. Same config with PARITY_MODE=2 then 1; push 0xA5 -> parity bit 0 (even) and 1 (odd), inserted after bit 7; frame length 110 cycles.
3. DATA_BITS=7, STOP_BITS=2; push 0x41 -> start, bits 1,0,0,0,0,0,1, then 20 cycles of high; total 100 cycles.
4. FIFO_DEPTH=4; push 6 words on consecutive cycles -> the first 5 are accepted (1 popped immediately, 4 buffered) and pi_ready=0 for the 6th; the frames follow back-to-back with the next start bit on the cycle after the final stop cycle and no idle gap.
5. Assert system_rst during data bit 3 of a frame with 2 words queued -> tx=1 on the same edge, fifo_count=0, busy=0; the next push transmits normally.
6. With the FIFO full, assert pi_valid in the same cycle as a STOP-end pop -> the push is rejected (pi_ready was 0); fifo_count goes from 4 to 3.
